timer_bank: RTL

- Parametrised successor to the fixed pair of discrete timers on the processor bus.
- One block holds N_CH independent down-counting timer channels behind a single bus port.
- Each channel has one-shot or auto-reload mode, a shared clock prescaler, a per-channel interrupt mask and a sticky write-1-to-clear pending flag.
- Sits behind the bridge and drives the CPU HWInt vector, one IRQ bit per channel.

---
 rtl/timer_bank_pkg.sv | 28 ++
 rtl/timer_bank_if.sv | 17 +
 rtl/timer_channel.sv | 80 ++++++++
 rtl/timer_bank.sv | 83 ++++++++
 4 files changed

// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: register offsets, CTRL bit positions,
// mode encodings and the per-channel state type.
package timer_bank_pkg;

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;
   localparam logic [1:0] OFF_STATUS = 2'd3;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;
   localparam int CTRL_IM   = 3;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_RELOAD  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2
   } ch_state_t;

   // Channel-select field width; a single channel still gets one address bit.
   function automatic int ch_aw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Register bus between the bridge and the timer bank, plus the IRQ vector.
// Reads are combinational, writes take effect at the clock edge; no backpressure.
interface timer_bank_if #(
   parameter int N_CH = 2
);
   localparam int AW = timer_bank_pkg::ch_aw(N_CH) + 2;

   logic [AW-1:0]   Addr;
   logic [31:0]     Wd;
   logic            We;
   logic [31:0]     Rd;
   logic [N_CH-1:0] IRQ;
   logic            IRQ_any;

   modport master (output Addr, Wd, We, input Rd, IRQ, IRQ_any);
   modport slave  (input Addr, Wd, We, output Rd, IRQ, IRQ_any);
endinterface

// File: rtl/timer_channel.sv
// One down-counting timer: CTRL/PRESET/COUNT/pending registers and IDLE/LOAD/CNT FSM.
// Writes land at the edge, irq is registered one cycle behind pending; never stalls.
module timer_channel import timer_bank_pkg::*; #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        we_ctrl,
   input  logic        we_preset,
   input  logic        we_status,
   input  logic [31:0] wd,
   output logic [31:0] ctrl_rd,
   output logic [31:0] preset_rd,
   output logic [31:0] count_rd,
   output logic [31:0] status_rd,
   output logic        irq
);

   ch_state_t        state;
   logic             en;
   logic             mode;
   logic             im;
   logic             pending;
   logic [WIDTH-1:0] preset;
   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         en      <= 1'b0;
         mode    <= MODE_ONESHOT;
         im      <= 1'b0;
         pending <= 1'b0;
         preset  <= '0;
         count   <= '0;
         irq     <= 1'b0;
      end else begin
         irq <= pending & im;
         if (we_preset)
            preset <= wd[WIDTH-1:0];
         // Clear is issued first so a terminal event in the same cycle overrides it.
         if (we_status && wd[0])
            pending <= 1'b0;
         if (we_ctrl) begin
            en    <= wd[CTRL_EN];
            mode  <= wd[CTRL_MODE];
            im    <= wd[CTRL_IM];
            state <= wd[CTRL_EN] ? ST_LOAD : ST_IDLE;
         end else begin
            case (state)
               ST_LOAD: begin
                  count <= preset;
                  state <= ST_CNT;
               end
               ST_CNT: begin
                  if (count == '0) begin
                     pending <= 1'b1;
                     if (mode == MODE_RELOAD) begin
                        state <= ST_LOAD;
                     end else begin
                        en    <= 1'b0;
                        state <= ST_IDLE;
                     end
                  end else if (tick) begin
                     count <= count - 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign ctrl_rd   = {28'd0, im, 1'b0, mode, en};
   assign preset_rd = 32'(preset);
   assign count_rd  = 32'(count);
   assign status_rd = {31'd0, pending};

endmodule

// File: rtl/timer_bank.sv
// N_CH timer channels behind one register port, sharing a free-running prescaler.
// Combinational read mux, edge-sampled writes, registered IRQ vector; no backpressure.
module timer_bank import timer_bank_pkg::*; #(
   parameter int N_CH     = 2,
   parameter int WIDTH    = 32,
   parameter int PRESCALE = 1
) (
   input  logic         Clk,
   input  logic         Reset,
   timer_bank_if.slave  bus
);

   localparam int CH_AW = ch_aw(N_CH);
   localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0]    pre_cnt;
   logic             tick;
   logic [CH_AW-1:0] ch_sel;
   logic [1:0]       reg_sel;
   logic             in_range;
   logic [31:0]      rd;
   logic [N_CH-1:0]  irq;
   logic [31:0]      ctrl_rd   [N_CH];
   logic [31:0]      preset_rd [N_CH];
   logic [31:0]      count_rd  [N_CH];
   logic [31:0]      status_rd [N_CH];

   // With PRESCALE=1 the counter is pinned at 0 and tick is permanently high.
   assign tick = (pre_cnt == P_LAST);

   always_ff @(posedge Clk) begin
      if (Reset)
         pre_cnt <= '0;
      else if (tick)
         pre_cnt <= '0;
      else
         pre_cnt <= pre_cnt + 1'b1;
   end

   assign ch_sel   = bus.Addr[CH_AW+1:2];
   assign reg_sel  = bus.Addr[1:0];
   assign in_range = (32'(ch_sel) < 32'(N_CH));

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic sel;
      assign sel = bus.We && in_range && (ch_sel == CH_AW'(i));

      timer_channel #(.WIDTH(WIDTH)) u_ch (
         .clk       (Clk),
         .rst       (Reset),
         .tick      (tick),
         .we_ctrl   (sel && (reg_sel == OFF_CTRL)),
         .we_preset (sel && (reg_sel == OFF_PRESET)),
         .we_status (sel && (reg_sel == OFF_STATUS)),
         .wd        (bus.Wd),
         .ctrl_rd   (ctrl_rd[i]),
         .preset_rd (preset_rd[i]),
         .count_rd  (count_rd[i]),
         .status_rd (status_rd[i]),
         .irq       (irq[i])
      );
   end

   always_comb begin
      rd = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (in_range && (ch_sel == CH_AW'(i))) begin
            case (reg_sel)
               OFF_CTRL:   rd = ctrl_rd[i];
               OFF_PRESET: rd = preset_rd[i];
               OFF_COUNT:  rd = count_rd[i];
               default:    rd = status_rd[i];
            endcase
         end
      end
   end

   assign bus.Rd      = rd;
   assign bus.IRQ     = irq;
   assign bus.IRQ_any = |irq;

endmodule
